// File: rtl/rv_io_arb.sv
`default_nettype none
// ============================================================================
// Module      : rv_io_arb
// Description : Round-robin arbiter of NREQ requesters onto a single slave port
//               with one outstanding transaction. Optional read timeout is
//               enabled by defining RV_IO_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_io_arb #(
    parameter int RV   = 64,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      m_addr_req,
    output logic [NREQ-1:0]      m_addr_ack,
    input  logic [NREQ*16-1:0]   m_addr,
    input  logic [NREQ-1:0]      m_read,
    input  logic [NREQ*8-1:0]    m_mask,
    input  logic [NREQ*RV-1:0]   m_wdata,
    output logic [NREQ-1:0]      m_data_req,
    input  logic [NREQ-1:0]      m_data_ack,
    output logic [RV-1:0]        m_rdata,
    output logic                 s_addr_req,
    output logic                 s_sel,
    input  logic                 s_addr_ack,
    output logic [15:0]          s_addr,
    output logic                 s_read,
    output logic [7:0]           s_mask,
    output logic [RV-1:0]        s_wdata,
    input  logic                 s_data_req,
    input  logic [RV-1:0]        s_rdata,
    output logic                 s_data_ack,
    output logic                 err
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_IW-1:0]    r_rr;
    logic [c_IW-1:0]    r_owner;
    logic [15:0]        r_addr;
    logic               r_read;
    logic [7:0]         r_mask;
    logic [RV-1:0]      r_wdata;

    logic               w_found;
    logic [c_IW-1:0]    w_owner;
    logic [NREQ-1:0]    w_grant_oh;
    logic [NREQ-1:0]    w_owner_oh;
    logic               w_owner_ack;
    logic               w_in_rd;
    logic               w_tmo;
    logic               w_rd_done;

    function automatic logic [c_IW-1:0] rot_idx(input logic [c_IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return c_IW'(s);
    endfunction

    // First pending requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_owner = r_rr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && m_addr_req[rot_idx(r_rr, k)]) begin
                w_found = 1'b1;
                w_owner = rot_idx(r_rr, k);
            end
        end
    end

    assign w_grant_oh  = NREQ'(1) << w_owner;
    assign w_owner_oh  = NREQ'(1) << r_owner;
    assign w_owner_ack = m_data_ack[r_owner];
    assign w_in_rd     = (r_state == S_RDWAIT);
    assign w_rd_done   = w_owner_ack && (s_data_req || w_tmo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_owner <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_mask  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_owner;
                        r_rr    <= (w_owner == c_IW'(NREQ - 1)) ? '0 : w_owner + c_IW'(1);
                        r_addr  <= m_addr[16*int'(w_owner) +: 16];
                        r_read  <= m_read[w_owner];
                        r_mask  <= m_mask[8*int'(w_owner) +: 8];
                        r_wdata <= m_wdata[RV*int'(w_owner) +: RV];
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s_addr_ack) r_state <= r_read ? S_RDWAIT : S_IDLE;
                end
                S_RDWAIT: begin
                    if (w_rd_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The grant is a same-cycle pulse, so it is gated by reset to stay quiet while reset is low.
    assign m_addr_ack = (reset && (r_state == S_IDLE) && w_found) ? w_grant_oh : '0;

    assign s_addr_req = (r_state == S_ADDR);
    assign s_sel      = s_addr_req;
    assign s_addr     = r_addr;
    assign s_read     = r_read;
    assign s_mask     = r_mask;
    assign s_wdata    = r_wdata;

    assign m_data_req = (w_in_rd && (s_data_req || w_tmo)) ? w_owner_oh : '0;
    assign m_rdata    = w_in_rd ? (w_tmo ? '1 : s_rdata) : '0;
    assign s_data_ack = w_in_rd && !w_tmo && w_owner_ack;

`ifdef RV_IO_ARB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_tmo_seen;

    // Counter saturates at 255; from then on the requester is answered with all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt  <= '0;
            r_tmo_seen <= 1'b0;
        end else if (!w_in_rd) begin
            r_tmo_cnt  <= '0;
            r_tmo_seen <= 1'b0;
        end else begin
            if (!s_data_req && !w_tmo) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_tmo) r_tmo_seen <= 1'b1;
        end
    end

    assign w_tmo = (r_tmo_cnt == 8'hFF);
    assign err   = w_in_rd && w_tmo && !r_tmo_seen;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_io_arb.sv
`default_nettype none
// Testbench for rv_io_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbiter.
module tb_rv_io_arb;

    localparam int RV   = 64;
    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     m_addr_req;
    logic [NREQ-1:0]     m_addr_ack;
    logic [NREQ*16-1:0]  m_addr;
    logic [NREQ-1:0]     m_read;
    logic [NREQ*8-1:0]   m_mask;
    logic [NREQ*RV-1:0]  m_wdata;
    logic [NREQ-1:0]     m_data_req;
    logic [NREQ-1:0]     m_data_ack;
    logic [RV-1:0]       m_rdata;
    logic                s_addr_req;
    logic                s_sel;
    logic                s_addr_ack;
    logic [15:0]         s_addr;
    logic                s_read;
    logic [7:0]          s_mask;
    logic [RV-1:0]       s_wdata;
    logic                s_data_req;
    logic [RV-1:0]       s_rdata;
    logic                s_data_ack;
    logic                err;

    always #5 clk = ~clk;

    rv_io_arb #(.RV(RV), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_addr_req (m_addr_req),
        .m_addr_ack (m_addr_ack),
        .m_addr     (m_addr),
        .m_read     (m_read),
        .m_mask     (m_mask),
        .m_wdata    (m_wdata),
        .m_data_req (m_data_req),
        .m_data_ack (m_data_ack),
        .m_rdata    (m_rdata),
        .s_addr_req (s_addr_req),
        .s_sel      (s_sel),
        .s_addr_ack (s_addr_ack),
        .s_addr     (s_addr),
        .s_read     (s_read),
        .s_mask     (s_mask),
        .s_wdata    (s_wdata),
        .s_data_req (s_data_req),
        .s_rdata    (s_rdata),
        .s_data_ack (s_data_ack),
        .err        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: round-robin pointer and the pending request of each requester.
    int              mdl_rr;
    logic            q_req   [NREQ];
    logic [15:0]     q_addr  [NREQ];
    logic            q_read  [NREQ];
    logic [7:0]      q_mask  [NREQ];
    logic [RV-1:0]   q_wdata [NREQ];

    task automatic chk(input string tag, input logic [RV-1:0] obs, input logic [RV-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NREQ-1:0] e_aack, input logic e_sreq,
                           input logic fld, input logic [15:0] ea, input logic er,
                           input logic [7:0] em, input logic [RV-1:0] ew,
                           input logic [NREQ-1:0] e_dreq, input logic [RV-1:0] e_rdata,
                           input logic e_sdack, input logic e_err);
        chk({tag, " m_addr_ack"}, m_addr_ack, e_aack);
        chk({tag, " s_addr_req"}, s_addr_req, e_sreq);
        chk({tag, " s_sel"},      s_sel,      e_sreq);
        chk({tag, " m_data_req"}, m_data_req, e_dreq);
        chk({tag, " m_rdata"},    m_rdata,    e_rdata);
        chk({tag, " s_data_ack"}, s_data_ack, e_sdack);
        chk({tag, " err"},        err,        e_err);
        if (fld) begin
            chk({tag, " s_addr"},  s_addr,  ea);
            chk({tag, " s_read"},  s_read,  er);
            chk({tag, " s_mask"},  s_mask,  em);
            chk({tag, " s_wdata"}, s_wdata, ew);
        end
    endtask

    task automatic drive_m();
        for (int i = 0; i < NREQ; i++) begin
            m_addr_req[i]         = q_req[i];
            m_addr[16*i +: 16]    = q_addr[i];
            m_read[i]             = q_read[i];
            m_mask[8*i +: 8]      = q_mask[i];
            m_wdata[RV*i +: RV]   = q_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input logic on, input logic rd, input logic [15:0] a,
                           input logic [7:0] mk, input logic [RV-1:0] wd);
        q_req[i] = on; q_read[i] = rd; q_addr[i] = a; q_mask[i] = mk; q_wdata[i] = wd;
    endtask

    task automatic rand_req(input int i, input logic force_on);
        set_req(i, force_on | 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 8'($urandom), {$urandom, $urandom});
    endtask

    function automatic int exp_owner();
        for (int k = 0; k < NREQ; k++) begin
            int j = (mdl_rr + k) % NREQ;
            if (q_req[j]) return j;
        end
        return -1;
    endfunction

    // One full transaction from the IDLE grant cycle back to IDLE.
    // mode: 0 = owner drops its request, 1 = keeps it, 2 = random new request.
    task automatic txn(input string tag, input int aw, input int dw, input int kw,
                       input int mode, input logic [RV-1:0] rdv);
        int              o;
        logic [15:0]     ea;
        logic            er;
        logic [7:0]      em;
        logic [RV-1:0]   ew;
        logic [RV-1:0]   junk;
        logic [NREQ-1:0] oh;
        o = exp_owner();
        if (o < 0) begin
            n_fail++;
            $display("FAIL %s: bench sequence has no pending requester", tag);
            return;
        end
        ea = q_addr[o]; er = q_read[o]; em = q_mask[o]; ew = q_wdata[o];
        oh = NREQ'(1) << o;
        @(negedge clk);
        chk_all({tag, ".grant"}, oh, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        mdl_rr = (o + 1) % NREQ;
        @(posedge clk); #1;
        if (mode == 0) q_req[o] = 1'b0;
        else if (mode == 2) rand_req(o, 1'b0);
        drive_m();
        for (int i = 0; i < aw; i++) begin
            s_addr_ack = 1'b0;
            @(negedge clk);
            chk_all({tag, ".addr_wait"}, '0, 1'b1, 1'b1, ea, er, em, ew, '0, '0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        s_addr_ack = 1'b1;
        @(negedge clk);
        chk_all({tag, ".addr"}, '0, 1'b1, 1'b1, ea, er, em, ew, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        s_addr_ack = 1'b0;
        if (er) begin
            for (int i = 0; i < dw; i++) begin
                junk = {$urandom, $urandom};
                s_data_req = 1'b0; s_rdata = junk;
                m_data_ack = NREQ'($urandom) & ~oh;
                @(negedge clk);
                chk_all({tag, ".rd_wait"}, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, junk, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
            s_data_req = 1'b1; s_rdata = rdv;
            for (int i = 0; i < kw; i++) begin
                m_data_ack = NREQ'($urandom) & ~oh;
                @(negedge clk);
                chk_all({tag, ".rd_hold"}, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, oh, rdv, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
            m_data_ack = NREQ'($urandom) | oh;
            @(negedge clk);
            chk_all({tag, ".rd_done"}, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, oh, rdv, 1'b1, 1'b0);
            @(posedge clk); #1;
            s_data_req = 1'b0; s_rdata = '0; m_data_ack = '0;
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
        drive_m();
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk_all(tag, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
        drive_m();
        s_addr_ack = 1'b1; s_data_req = 1'b1; s_rdata = '1; m_data_ack = '1;
        @(negedge clk);
        chk_all(tag, '0, 1'b0, 1'b1, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        clear_reqs();
        s_addr_ack = 1'b0; s_data_req = 1'b0; s_rdata = '0; m_data_ack = '0;
        reset = 1'b1;
        mdl_rr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        s_addr_ack = 1'b0; s_data_req = 1'b0; s_rdata = '0; m_data_ack = '0;
        clear_reqs();
        mdl_rr = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with every input active: outputs and captured fields all zero.
        do_reset("reset");

        // Single write from requester 0, slave accepts in the first ADDR cycle.
        set_req(0, 1'b1, 1'b0, 16'h4000, 8'hFF, 64'h1234);
        drive_m();
        txn("wr0", 0, 0, 0, 0, '0);
        idle_check("wr0.idle");

        // Both requesters write continuously from reset: grants alternate 0,1,0,1.
        do_reset("reset2");
        set_req(0, 1'b1, 1'b0, 16'h1000, 8'h0F, 64'hAAAA_0000_0000_0001);
        set_req(1, 1'b1, 1'b0, 16'h2000, 8'hF0, 64'h5555_0000_0000_0002);
        drive_m();
        for (int k = 0; k < 6; k++) txn("alt", 0, 0, 0, 1, '0);

        // Slave withholds s_addr_ack for 5 cycles while both keep requesting.
        txn("hold", 5, 0, 0, 1, '0);
        clear_reqs();
        idle_check("hold.idle");

        // Requester 1 read: data after 3 cycles, requester acks 2 cycles later.
        set_req(1, 1'b1, 1'b1, 16'hBFF8, 8'h00, '0);
        drive_m();
        txn("rd1", 0, 3, 2, 0, 64'hDEAD);
        idle_check("rd1.idle");

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!q_req[i] && $urandom_range(0, 3) == 0) rand_req(i, 1'b1);
            if (exp_owner() < 0) rand_req(int'($urandom_range(0, NREQ - 1)), 1'b1);
            drive_m();
            txn("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 2, {$urandom, $urandom});
        end
        clear_reqs();
        idle_check("rnd.idle");

        // Reset during RDWAIT abandons the transaction; arbitration restarts at 0.
        set_req(0, 1'b1, 1'b1, 16'h0100, 8'h00, '0);
        drive_m();
        mdl_rr = 0;
        do_reset("reset3");
        set_req(0, 1'b1, 1'b1, 16'h0100, 8'h00, '0);
        drive_m();
        @(negedge clk);
        chk_all("rst_rd.grant", 2'b01, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        clear_reqs();
        s_addr_ack = 1'b1;
        @(posedge clk); #1;
        s_addr_ack = 1'b0;
        s_data_req = 1'b1; s_rdata = 64'hDEAD; m_data_ack = 2'b01;
        #2;
        chk_all("rst_rd.rdwait", '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 2'b01, 64'hDEAD, 1'b1, 1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 16'h3000 + 16'(i), 8'h3C, 64'(i));
        drive_m();
        #1 reset = 1'b0;
        #1;
        chk_all("rst_rd.async", '0, 1'b0, 1'b1, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("rst_rd.held", '0, 1'b0, 1'b1, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        s_data_req = 1'b0; s_rdata = '0; m_data_ack = '0;
        reset = 1'b1;
        mdl_rr = 0;
        txn("post_rst", 0, 0, 0, 0, '0);
        txn("post_rst2", 0, 0, 0, 0, '0);
        idle_check("post_rst.idle");

`ifdef RV_IO_ARB_TIMEOUT_EN
        // Unanswered read: err after 255 RDWAIT cycles, all-ones returned.
        begin
            int o;
            logic [NREQ-1:0] oh;
            set_req(0, 1'b1, 1'b1, 16'h7FF0, 8'h00, '0);
            drive_m();
            o  = exp_owner();
            oh = NREQ'(1) << o;
            @(negedge clk);
            chk_all("tmo.grant", oh, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
            mdl_rr = (o + 1) % NREQ;
            @(posedge clk); #1;
            clear_reqs();
            s_addr_ack = 1'b1;
            @(posedge clk); #1;
            s_addr_ack = 1'b0;
            for (int k = 0; k < 258; k++) begin
                @(negedge clk);
                chk_all("tmo.wait", '0, 1'b0, 1'b0, '0, 1'b0, '0, '0,
                        (k >= 255) ? oh : '0, (k >= 255) ? '1 : '0, 1'b0, (k == 255));
                @(posedge clk); #1;
            end
            m_data_ack = oh;
            @(negedge clk);
            chk_all("tmo.ack", '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, oh, '1, 1'b0, 1'b0);
            @(posedge clk); #1;
            m_data_ack = '0;
            idle_check("tmo.idle");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
